axis_byte_packetizer: RTL and testbench

Frames the 8-bit AXI stream from the IQ-sample-to-AXIS adapter into fixed-length packets for the host link:
- two sync bytes;
- an 8-bit sequence number;
- PAYLOAD_LEN payload bytes;
- an optional XOR checksum byte.

It sits directly downstream of the adapter and upstream of the byte transport (UART/USB FIFO). The host uses it to find packet boundaries and detect lost packets.

---
 rtl/axis_byte_packetizer.sv | 144 ++++++++++++++
 tb/tb_axis_byte_packetizer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_byte_packetizer.sv
// Frames an 8-bit AXI stream into sync(2) + sequence(1) + payload(PAYLOAD_LEN) packets.
// Define AXIS_PKT_CHECKSUM_EN to append an XOR checksum byte after the payload.
module axis_byte_packetizer #(
  parameter int          PAYLOAD_LEN = 240,
  parameter logic [15:0] SYNC_WORD   = 16'hA55A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic [7:0] pkt_seq,
  output logic       misalign
);

  localparam int               CNT_W    = $clog2(PAYLOAD_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC0,
    SYNC1,
    SEQ,
`ifdef AXIS_PKT_CHECKSUM_EN
    PAYLOAD,
    CHK
`else
    PAYLOAD
`endif
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_phase;   // position within the current 3-byte IQ sample
  logic [7:0]       r_seq;
  logic             r_misalign;
  logic             w_pay_acc;
  logic             w_pay_last;
  logic             w_seq_acc;
  logic             w_pkt_done;

  assign w_pay_acc  = (r_state == PAYLOAD) && s_axis_tvalid && m_axis_tready;
  assign w_pay_last = (r_cnt == LAST_IDX);
  assign w_seq_acc  = (r_state == SEQ) && m_axis_tready;
  assign pkt_seq    = r_seq;
  assign misalign   = r_misalign;

`ifdef AXIS_PKT_CHECKSUM_EN
  logic [7:0] r_chk;

  assign w_pkt_done = (r_state == CHK) && m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_chk <= 8'h00;
    end else if (w_seq_acc) begin
      r_chk <= r_seq;
    end else if (w_pay_acc) begin
      r_chk <= r_chk ^ s_axis_tdata;
    end
  end
`else
  assign w_pkt_done = w_pay_acc && w_pay_last;
`endif

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_next        = r_state;
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_axis_tvalid) w_next = SYNC0;
      end
      SYNC0: begin
        m_axis_tdata  = SYNC_WORD[15:8];
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) w_next = SYNC1;
      end
      SYNC1: begin
        m_axis_tdata  = SYNC_WORD[7:0];
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) w_next = SEQ;
      end
      SEQ: begin
        m_axis_tdata  = r_seq;
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) w_next = PAYLOAD;
      end
      PAYLOAD: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
`ifdef AXIS_PKT_CHECKSUM_EN
        if (w_pay_acc && w_pay_last) w_next = CHK;
`else
        m_axis_tlast  = s_axis_tvalid && w_pay_last;
        if (w_pay_acc && w_pay_last) w_next = IDLE;
`endif
      end
`ifdef AXIS_PKT_CHECKSUM_EN
      CHK: begin
        m_axis_tdata  = r_chk;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) w_next = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_phase    <= 2'd0;
      r_seq      <= 8'h00;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_misalign <= 1'b0;
      if (w_seq_acc) begin
        r_cnt   <= '0;
        r_phase <= 2'd0;
      end else if (w_pay_acc) begin
        r_cnt      <= r_cnt + 1'b1;
        r_phase    <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
        r_misalign <= s_axis_tlast != (r_phase == 2'd2);
      end
      if (w_pkt_done) r_seq <= r_seq + 8'd1;
    end
  end

endmodule

// File: tb/tb_axis_byte_packetizer.sv
// Self-checking bench for axis_byte_packetizer (PAYLOAD_LEN=6) against a packet-level model.
module tb_axis_byte_packetizer;

  localparam int          PL = 6;
  localparam logic [15:0] SW = 16'hA55A;
`ifdef AXIS_PKT_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
  localparam int OVH    = 5;
`else
  localparam bit CHK_EN = 1'b0;
  localparam int OVH    = 4;
`endif

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       mis;
  } in_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] seq;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic [7:0] pkt_seq;
  logic       misalign;

  axis_byte_packetizer #(.PAYLOAD_LEN(PL), .SYNC_WORD(SW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_seq       (pkt_seq),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         ticks;
  int         consumed;
  int         ready_mode;   // 0 always ready, 1 toggling, 2 random
  bit         valid_rand;
  in_t        in_q[$];
  out_t       exp_q[$];
  logic [7:0] model_seq;
  logic       exp_mis;
  logic       held;
  logic [7:0] held_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Appends one packet to the source stream and its framed image to the expected output.
  task automatic add_packet(input int kind);
    logic [7:0] x;
    logic       want;
    in_t        i;
    out_t       o;
    x     = model_seq;
    o.seq = model_seq;
    o.last = 1'b0;
    o.data = SW[15:8];  exp_q.push_back(o);
    o.data = SW[7:0];   exp_q.push_back(o);
    o.data = model_seq; exp_q.push_back(o);
    for (int k = 1; k <= PL; k++) begin
      i.data = (kind == 0) ? 8'(k) : 8'($urandom);
      want   = (k % 3 == 0);
      i.last = want;
      if (kind == 2 && k == 2) i.last = 1'b1;
      if (kind == 2 && k == 3) i.last = 1'b0;
      if (kind == 3 && $urandom_range(0, 7) == 0) i.last = !i.last;
      i.mis = (i.last != want);
      in_q.push_back(i);
      x ^= i.data;
      o.data = i.data;
      o.last = !CHK_EN && (k == PL);
      exp_q.push_back(o);
    end
    if (CHK_EN) begin
      o.data = x;
      o.last = 1'b1;
      exp_q.push_back(o);
    end
    model_seq++;
  endtask

  task automatic drive();
    if (in_q.size() > 0 && (!valid_rand || $urandom_range(0, 3) != 0)) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = in_q[0].data;
      s_axis_tlast  = in_q[0].last;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tlast  = 1'b0;
    end
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = !m_axis_tready;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic tick();
    out_t e;
    @(negedge clk);
    ticks++;
    check("misalign", 32'(misalign), 32'(exp_mis));
    if (!valid_rand && held) begin
      check("hold_valid", 32'(m_axis_tvalid), 32'd1);
      check("hold_data", 32'(m_axis_tdata), 32'(held_data));
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL extra_byte: observed=%0h expected=none", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        check("tdata", 32'(m_axis_tdata), 32'(e.data));
        check("tlast", 32'(m_axis_tlast), 32'(e.last));
        check("pkt_seq", 32'(pkt_seq), 32'(e.seq));
      end
    end
    held      = m_axis_tvalid && !m_axis_tready;
    held_data = m_axis_tdata;
    exp_mis   = 1'b0;
    if (s_axis_tvalid && s_axis_tready && in_q.size() > 0) begin
      exp_mis = in_q[0].mis;
      void'(in_q.pop_front());
      consumed++;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
    check({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
    check({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
    check({tag, "_pkt_seq"}, 32'(pkt_seq), 32'd0);
    check({tag, "_misalign"}, 32'(misalign), 32'd0);
  endtask

  task automatic clear_model();
    in_q.delete();
    exp_q.delete();
    model_seq = 8'h00;
    exp_mis   = 1'b0;
    held      = 1'b0;
    consumed  = 0;
  endtask

  // Reset is held with a valid byte offered, so tready/tdata being 0 is meaningful.
  task automatic do_reset(input int rmode, input bit vrand);
    rst           = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'hFF;
    s_axis_tlast  = 1'b1;
    m_axis_tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_idle_outputs("reset");
    clear_model();
    ready_mode = rmode;
    valid_rand = vrand;
    rst        = 1'b1;
  endtask

  task automatic drain(input int budget, input int exp_ticks);
    ticks = 0;
    while (exp_q.size() != 0 && ticks < budget) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL timeout: observed=%0d bytes left expected=0", exp_q.size());
      clear_model();
    end else if (exp_ticks > 0) begin
      check("cycles", 32'(ticks), 32'(exp_ticks));
    end
    tick();
    tick();
    check("idle_after", 32'(m_axis_tvalid), 32'd0);
  endtask

  initial begin
    ready_mode = 0;
    valid_rand = 1'b0;
    clear_model();

    // Directed ramp 01..06, downstream always ready: exact byte stream and cycle count.
    do_reset(0, 1'b0);
    add_packet(0);
    drive();
    @(negedge clk);
    check("idle_first_valid", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk);
    #1;
    check("sync0_latency", 32'(m_axis_tvalid), 32'd1);
    check("sync0_byte", 32'(m_axis_tdata), 32'(SW[15:8]));
    do_reset(0, 1'b0);
    add_packet(0);
    drive();
    drain(100, PL + OVH);

    // Same stimulus with toggling backpressure: held bytes must stay put.
    do_reset(1, 1'b0);
    add_packet(0);
    drive();
    drain(200, 0);

    // 257 back-to-back random packets: sequence wrap and no-bubble framing.
    do_reset(0, 1'b0);
    repeat (257) add_packet(1);
    drive();
    drain(257 * (PL + OVH) + 50, 257 * (PL + OVH));

    // Random data, random tlast faults, random valid and ready.
    do_reset(2, 1'b1);
    repeat (20) add_packet(3);
    drive();
    drain(5000, 0);

    // Reset pulse right after payload byte 3, then a fresh packet from seq 0.
    do_reset(0, 1'b0);
    add_packet(1);
    drive();
    ticks = 0;
    while (consumed < 3 && ticks < 100) tick();
    check("mid_reset_reached", 32'(consumed), 32'd3);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_idle_outputs("mid_reset");
    clear_model();
    add_packet(1);
    drive();
    drain(100, PL + OVH);

    // tlast on payload byte 2 instead of 3; packet length is unchanged.
    do_reset(0, 1'b0);
    add_packet(2);
    drive();
    drain(100, PL + OVH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
